// File: rtl/ascon_permutation_sequencer_pkg.sv
// Shared types, constants and the round-constant helper for the ASCON
// permutation sequencer and its combinational round.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_seq_state;

    localparam int NB_ROUNDS_MAX = 12;
    localparam int ROUNDS_A      = 12;
    localparam int ROUNDS_B      = 6;

    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/ascon_permutation_sequencer_round.sv
// One ASCON round: constant addition, bitsliced 5-bit S-box layer and
// per-word linear diffusion. Purely combinational.
module permutation_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [7:0] const_i,
    output type_state  state_o
);

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    // Constant lands in the low byte of word 2, then the S-box input mixing.
    assign a0 = state_i[0] ^ state_i[4];
    assign a1 = state_i[1];
    assign a2 = state_i[2] ^ {56'd0, const_i} ^ state_i[1];
    assign a3 = state_i[3];
    assign a4 = state_i[4] ^ state_i[3];

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign state_o[0] = c0 ^ rotr(c0, 19) ^ rotr(c0, 28);
    assign state_o[1] = c1 ^ rotr(c1, 61) ^ rotr(c1, 39);
    assign state_o[2] = c2 ^ rotr(c2, 1)  ^ rotr(c2, 6);
    assign state_o[3] = c3 ^ rotr(c3, 10) ^ rotr(c3, 17);
    assign state_o[4] = c4 ^ rotr(c4, 7)  ^ rotr(c4, 41);

endmodule

// File: rtl/ascon_permutation_sequencer.sv
// Applies p^a or p^b one round per clock to an owned 320-bit state register,
// with a ready/start request and a one-cycle done pulse.
module ascon_permutation_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 rounds_sel_i,
    input  ascon_pack::type_state state_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [3:0]           round_o,
    output ascon_pack::type_state state_o
);
    import ascon_pack::*;

    localparam logic [3:0] CNT_START_A = 4'(NB_ROUNDS_MAX - ROUNDS_A);
    localparam logic [3:0] CNT_START_B = 4'(NB_ROUNDS_MAX - ROUNDS_B);
    localparam logic [3:0] CNT_LAST    = 4'(NB_ROUNDS_MAX - 1);

    type_seq_state fsm_q, fsm_d;
    logic [3:0]    cnt_q, cnt_d;
    type_state     state_q, state_d;
    type_state     round_out;

    permutation_round u_round (
        .state_i (state_q),
        .const_i (round_constant(cnt_q)),
        .state_o (round_out)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            RUN: begin
                state_d = round_out;
                // Counter stops at the last index so it never reads past 11.
                if (cnt_q == CNT_LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (start_i) begin
                    state_d = state_i;
                    cnt_d   = rounds_sel_i ? CNT_START_B : CNT_START_A;
                    fsm_d   = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
        endcase
    end

    assign ready_o = (fsm_q != RUN);
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);
    assign round_o = cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_sequencer.sv
// Directed bench for the ASCON permutation sequencer, with a table-driven
// S-box reference model for the permutation results.
module tb_ascon_permutation_sequencer;
    import ascon_pack::*;

    logic      clk = 1'b0;
    logic      reset, start, sel;
    type_state st_in, st_out;
    logic      ready, busy, done;
    logic [3:0] rnd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_permutation_sequencer dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .start_i      (start),
        .rounds_sel_i (sel),
        .state_i      (st_in),
        .ready_o      (ready),
        .busy_o       (busy),
        .done_o       (done),
        .round_o      (rnd),
        .state_o      (st_out)
    );

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [63:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = {y[0], y[63:1]};
        return y;
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        type_state  t;
        logic [4:0] idx, o;
        logic [7:0] c;
        c = 8'(((15 - r) << 4) | r);
        s[2][7:0] = s[2][7:0] ^ c;
        for (int j = 0; j < 64; j++) begin
            idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o = SBOX[idx];
            t[0][j] = o[4];
            t[1][j] = o[3];
            t[2][j] = o[2];
            t[3][j] = o[1];
            t[4][j] = o[0];
        end
        t[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
        t[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
        t[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
        t[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
        t[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
        return t;
    endfunction

    function automatic type_state model_perm(input type_state s, input int n);
        type_state t;
        t = s;
        for (int r = 12 - n; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel = 1'b0; st_in = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ready, busy, done, rnd} !== {1'b1, 1'b0, 1'b0, 4'd0} || st_out !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: rdy/busy/done/rnd=%b%b%b/%0d state=%h, want 100/0 state=0",
                         i, ready, busy, done, rnd, st_out);
            end
            tick();
        end
    endtask

    task automatic test_pa_zero();
        type_state exp;
        exp = model_perm('0, 12);
        sel = 1'b0; st_in = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy, done, ready, rnd} !== {1'b1, 1'b0, 1'b0, 4'(i)}) begin
                errors++;
                $display("FAIL pa_zero_run cyc%0d: busy/done/rdy=%b%b%b rnd=%0d, want 100 rnd=%0d",
                         i, busy, done, ready, rnd, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || st_out !== exp || rnd !== 4'd11) begin
            errors++;
            $display("FAIL pa_zero_done: done=%b rdy=%b rnd=%0d state=%h want done=1 rnd=11 state=%h",
                     done, ready, rnd, st_out, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || st_out !== exp) begin
            errors++;
            $display("FAIL pa_zero_after: done=%b busy=%b rdy=%b state=%h want 0/0/1 state=%h",
                     done, busy, ready, st_out, exp);
        end
    endtask

    task automatic test_pb_ones();
        type_state ones, exp;
        ones = '1;
        exp = model_perm(ones, 6);
        sel = 1'b1; st_in = ones; start = 1'b1;
        tick();
        start = 1'b0; sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({busy, done, rnd} !== {1'b1, 1'b0, 4'(6 + i)}) begin
                errors++;
                $display("FAIL pb_ones_run cyc%0d: busy/done=%b%b rnd=%0d, want 10 rnd=%0d",
                         i, busy, done, rnd, 6 + i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || st_out !== exp) begin
            errors++;
            $display("FAIL pb_ones_done: done=%b state=%h want done=1 state=%h", done, st_out, exp);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        type_state exp, other;
        exp = model_perm('0, 12);
        other = {64'hdeadbeefcafef00d, 64'h1, 64'h2, 64'h3, 64'h4};
        sel = 1'b0; st_in = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy, done, rnd} !== {1'b1, 1'b0, 4'(i)}) begin
                errors++;
                $display("FAIL busy_start_run cyc%0d: busy/done=%b%b rnd=%0d, want 10 rnd=%0d",
                         i, busy, done, rnd, i);
            end
            if (i == 3 || i == 8) begin
                start = 1'b1; st_in = other; sel = 1'b1;
            end else begin
                start = 1'b0; st_in = '0; sel = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || st_out !== exp) begin
            errors++;
            $display("FAIL busy_start_done: done=%b state=%h want done=1 state=%h", done, st_out, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        type_state a, b, exp_a, exp_b;
        a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f,
             64'h8000000000000001, 64'h00000000ffffffff};
        b = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
             64'h4444444444444444, 64'h5555555555555555};
        exp_a = model_perm(a, 6);
        exp_b = model_perm(b, 12);
        sel = 1'b1; st_in = a; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || st_out !== exp_a) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b rdy=%b state=%h want done=1 rdy=1 state=%h",
                     done, ready, st_out, exp_a);
        end
        sel = 1'b0; st_in = b; start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || rnd !== 4'd0 || st_out !== b) begin
            errors++;
            $display("FAIL b2b_reload: done=%b busy=%b rnd=%0d state=%h want 0/1 rnd=0 state=%h",
                     done, busy, rnd, st_out, b);
        end
        start = 1'b0;
        for (int i = 1; i < 12; i++) tick();
        checks++;
        if (done !== 1'b0 || rnd !== 4'd11) begin
            errors++;
            $display("FAIL b2b_early: done=%b rnd=%0d want done=0 rnd=11", done, rnd);
        end
        tick();
        checks++;
        if (done !== 1'b1 || st_out !== exp_b) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b state=%h want done=1 state=%h", done, st_out, exp_b);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        type_state c, exp_c;
        int done_seen;
        c = {64'h0, 64'h0, 64'h0, 64'h0, 64'h80400c0600000000};
        exp_c = model_perm(c, 6);
        sel = 1'b0; st_in = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (rnd !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_round: rnd=%0d busy=%b want rnd=5 busy=1", rnd, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ready, busy, done, rnd} !== {1'b1, 1'b0, 1'b0, 4'd0} || st_out !== '0) begin
            errors++;
            $display("FAIL midrun_reset: rdy/busy/done=%b%b%b rnd=%0d state=%h want 100 rnd=0 state=0",
                     ready, busy, done, rnd, st_out);
        end
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrun_no_done: done seen %0d times, want 0", done_seen);
        end
        sel = 1'b1; st_in = c; start = 1'b1;
        tick();
        start = 1'b0; sel = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done !== 1'b1 || st_out !== exp_c) begin
            errors++;
            $display("FAIL midrun_fresh: done=%b state=%h want done=1 state=%h", done, st_out, exp_c);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; st_in = '0;
        test_reset();
        test_pa_zero();
        test_pb_ones();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
